// File: rtl/div_result_display_pkg.sv
// Shared definitions for the divider result display: FSM state codes, segment
// patterns and the single double-dabble iteration used by the converter.
package div_result_display_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_SHOW = 2'd2;

  // Active-low segment patterns, bit 0 = segment a, bit 6 = segment g.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  // {BCD tens, BCD ones, remaining binary bits}, shifted left as one register.
  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
    logic [3:0] bin;
  } dabble_t;

  localparam int CONV_ITERS = 4;

  // One shift-add-3 step. A 4-bit operand never exceeds 15, so the tens
  // nibble stays at 0 or 1 and never needs its own correction.
  function automatic dabble_t dabble_step(input dabble_t cur);
    dabble_t adj;
    adj = cur;
    if (adj.ones >= 4'd5) adj.ones = adj.ones + 4'd3;
    return dabble_t'({adj.tens, adj.ones, adj.bin} << 1);
  endfunction

endpackage

// File: rtl/div_result_display_seven_seg.sv
// Combinational BCD to active-low seven-segment decoder with a blank override.
module seven_seg_decoder
  import div_result_display_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  // NOTE: the default before the case keeps every path assigned, so no latch is inferred.
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0: seg = SEG_0;
        4'd1: seg = SEG_1;
        4'd2: seg = SEG_2;
        4'd3: seg = SEG_3;
        4'd4: seg = SEG_4;
        4'd5: seg = SEG_5;
        4'd6: seg = SEG_6;
        4'd7: seg = SEG_7;
        4'd8: seg = SEG_8;
        4'd9: seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/div_result_display.sv
// Captures the divider's quotient/remainder, converts both to BCD with a
// 4-cycle double-dabble engine and drives four active-low seven-segment digits.
module div_result_display
  import div_result_display_pkg::*;
#(
  parameter int BLANK_LEADING = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] q,
  input  logic [3:0] r,
  input  logic       div_zero,
  output logic       busy,
  output logic       done,
  output logic [6:0] hex3,
  output logic [6:0] hex2,
  output logic [6:0] hex1,
  output logic [6:0] hex0
);

  logic [1:0] state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  dabble_t    quo_q, quo_d;
  dabble_t    rem_q, rem_d;
  logic       dz_q, dz_d;
  logic       done_q;
  logic [6:0] hex3_q, hex2_q, hex1_q, hex0_q;

  logic [6:0] seg_qt, seg_qo, seg_rt, seg_ro;
  logic       blank_qt, blank_rt;

  assign blank_qt = (BLANK_LEADING != 0) && (quo_q.tens == 4'd0);
  assign blank_rt = (BLANK_LEADING != 0) && (rem_q.tens == 4'd0);

  seven_seg_decoder u_dec_qt (.bcd(quo_q.tens), .blank(blank_qt), .seg(seg_qt));
  seven_seg_decoder u_dec_qo (.bcd(quo_q.ones), .blank(1'b0),     .seg(seg_qo));
  seven_seg_decoder u_dec_rt (.bcd(rem_q.tens), .blank(blank_rt), .seg(seg_rt));
  seven_seg_decoder u_dec_ro (.bcd(rem_q.ones), .blank(1'b0),     .seg(seg_ro));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          quo_d   = '{tens: 4'd0, ones: 4'd0, bin: q};
          rem_d   = '{tens: 4'd0, ones: 4'd0, bin: r};
          dz_d    = div_zero;
          cnt_d   = 2'd0;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        quo_d = dabble_step(quo_q);
        rem_d = dabble_step(rem_q);
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'(CONV_ITERS - 1)) state_d = ST_SHOW;
      end
      ST_SHOW: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      hex3_q  <= SEG_BLANK;
      hex2_q  <= SEG_BLANK;
      hex1_q  <= SEG_BLANK;
      hex0_q  <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      done_q  <= (state_q == ST_SHOW);
      if (state_q == ST_SHOW) begin
        if (dz_q) begin
          hex3_q <= SEG_E;
          hex2_q <= SEG_R;
          hex1_q <= SEG_R;
          hex0_q <= SEG_BLANK;
        end else begin
          hex3_q <= seg_qt;
          hex2_q <= seg_qo;
          hex1_q <= seg_rt;
          hex0_q <= seg_ro;
        end
      end
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hex3 = hex3_q;
  assign hex2 = hex2_q;
  assign hex1 = hex1_q;
  assign hex0 = hex0_q;

endmodule
